// File: rtl/musa_pkg.sv
// Shared definitions for the multicycle core: address width, PC-source and
// stage encodings, plus the stack operation decode used by the return stack.
package musa_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  typedef enum logic [2:0] {
    PCSRC_STACK  = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_SEQ    = 3'b010,
    PCSRC_JUMP   = 3'b011,
    PCSRC_HALT   = 3'b100
  } pcsrc_e;

  typedef enum logic [2:0] {
    STAGE_IF  = 3'b000,
    STAGE_ID  = 3'b001,
    STAGE_EX  = 3'b010,
    STAGE_MEM = 3'b011,
    STAGE_WB  = 3'b100
  } stage_e;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_op_e;

endpackage

// File: rtl/return_addr_stack_if.sv
// Control-unit <-> return stack interface; the control unit is the master.
interface return_addr_stack_if
  import musa_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic              aux_push_pop;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_valid;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, aux_push_pop, push_addr,
    input  ret_addr, ret_valid, top_addr, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, aux_push_pop, push_addr,
    output ret_addr, ret_valid, top_addr, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack_storage.sv
// Return-address storage: one synchronous write port, one asynchronous read
// port, no reset so it can map onto distributed RAM.
module ras_storage #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ADDR_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ADDR_W-1:0]        rdata_o
);
  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/return_addr_stack.sv
// Hardware call/return stack: CALL pushes PC+4, RET pops it onto ret_addr,
// one operation per rising edge of the control unit's aux qualifier.
module return_addr_stack
  import musa_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = 16
) (
  input logic                clk,
  input logic                reset,
  return_addr_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic              aux_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] ret_addr_q;
  logic              ret_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  logic              fire;
  logic              empty;
  logic              full;
  ras_op_e           op;
  logic [CNT_W-1:0]  count_m1;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              we;
  logic [ADDR_W-1:0] top_data;

  assign fire     = bus.aux_push_pop & ~aux_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count_m1 = count_q - CNT_W'(1);
  assign top_idx  = count_m1[IDX_W-1:0];

  always_comb begin
    op = RAS_NONE;
    case ({bus.pop, bus.push})
      2'b01:   op = RAS_PUSH;
      2'b10:   op = RAS_POP;
      2'b11:   op = RAS_REPLACE;
      default: op = RAS_NONE;
    endcase
  end

  // A replace on an empty stack degenerates into a plain push at slot 0.
  assign wr_idx = (op == RAS_REPLACE && !empty) ? top_idx : count_q[IDX_W-1:0];
  assign we     = fire & ~reset &
                  (((op == RAS_PUSH) & ~full) | (op == RAS_REPLACE));

  ras_storage #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_idx),
    .wdata_i (bus.push_addr),
    .raddr_i (top_idx),
    .rdata_o (top_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aux_q       <= 1'b0;
      count_q     <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      aux_q       <= bus.aux_push_pop;
      ret_valid_q <= 1'b0;
      if (fire) begin
        case (op)
          RAS_PUSH: begin
            if (full) overflow_q <= 1'b1;
            else      count_q    <= count_q + CNT_W'(1);
          end
          RAS_POP: begin
            if (empty) begin
              underflow_q <= 1'b1;
            end else begin
              ret_addr_q  <= top_data;
              ret_valid_q <= 1'b1;
              count_q     <= count_m1;
            end
          end
          RAS_REPLACE: begin
            if (empty) begin
              underflow_q <= 1'b1;
              count_q     <= count_q + CNT_W'(1);
            end else begin
              ret_addr_q  <= top_data;
              ret_valid_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.top_addr  = empty ? '0 : top_data;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed test of return_addr_stack: push/pop ordering, saturation, sticky
// flags, edge-qualified firing, replace, and reset dominance.
module tb_return_addr_stack;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  return_addr_stack_if #(.ADDR_W(32), .DEPTH(16)) bus ();

  return_addr_stack #(.ADDR_W(32), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One idle cycle, then a single-cycle aux pulse; returns on the negedge
  // after the fire edge, when results are visible.
  task automatic op(input logic p, input logic q, input logic [31:0] addr);
    @(negedge clk);
    bus.push = p;
    bus.pop = q;
    bus.push_addr = addr;
    bus.aux_push_pop = 1'b1;
    @(negedge clk);
    bus.aux_push_pop = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pop [3];
    exp_pop[0] = 32'h300;
    exp_pop[1] = 32'h200;
    exp_pop[2] = 32'h100;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.aux_push_pop = 1'b0;
    bus.push_addr = '0;
    do_reset();

    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_ret_addr", bus.ret_addr, 0);
    check("rst_ret_valid", 32'(bus.ret_valid), 0);
    check("rst_top", bus.top_addr, 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_unf", 32'(bus.underflow), 0);

    // 1: LIFO ordering with one-cycle ret_valid pulses
    op(1, 0, 32'h100);
    check("t1_top_after_push", bus.top_addr, 32'h100);
    op(1, 0, 32'h200);
    op(1, 0, 32'h300);
    check("t1_count3", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 32'h0);
      check($sformatf("t1_pop%0d_addr", i), bus.ret_addr, exp_pop[i]);
      check($sformatf("t1_pop%0d_valid", i), 32'(bus.ret_valid), 1);
      @(negedge clk);
      check($sformatf("t1_pop%0d_valid_drop", i), 32'(bus.ret_valid), 0);
      check($sformatf("t1_pop%0d_addr_hold", i), bus.ret_addr, exp_pop[i]);
    end
    check("t1_empty", 32'(bus.empty), 1);
    check("t1_count0", 32'(bus.count), 0);

    // 2: fill to DEPTH, then overflow
    for (int i = 0; i < 16; i++) op(1, 0, 32'h1000 + 32'(i));
    check("t2_full", 32'(bus.full), 1);
    check("t2_count16", 32'(bus.count), 16);
    check("t2_ovf_before", 32'(bus.overflow), 0);
    op(1, 0, 32'hDEAD);
    check("t2_ovf", 32'(bus.overflow), 1);
    check("t2_top", bus.top_addr, 32'h100F);
    check("t2_count_sat", 32'(bus.count), 16);

    // 3: underflow from reset
    do_reset();
    op(0, 1, 32'h0);
    check("t3_unf", 32'(bus.underflow), 1);
    check("t3_valid", 32'(bus.ret_valid), 0);
    check("t3_ret_addr", bus.ret_addr, 0);
    check("t3_count", 32'(bus.count), 0);
    @(negedge clk);
    check("t3_valid_later", 32'(bus.ret_valid), 0);
    check("t3_unf_sticky", 32'(bus.underflow), 1);

    // 4: aux held high fires exactly once
    do_reset();
    @(negedge clk);
    bus.push = 1'b1;
    bus.push_addr = 32'h44;
    bus.aux_push_pop = 1'b1;
    repeat (4) @(negedge clk);
    bus.aux_push_pop = 1'b0;
    bus.push = 1'b0;
    check("t4_count_held", 32'(bus.count), 1);
    check("t4_top_held", bus.top_addr, 32'h44);
    op(1, 0, 32'h48);
    check("t4_count2", 32'(bus.count), 2);
    check("t4_top2", bus.top_addr, 32'h48);
    op(0, 0, 32'h99);
    check("t4_nop_count", 32'(bus.count), 2);
    check("t4_nop_top", bus.top_addr, 32'h48);

    // 5: simultaneous push and pop replaces the top
    do_reset();
    op(1, 0, 32'h10);
    op(1, 0, 32'h20);
    op(1, 1, 32'h30);
    check("t5_ret_addr", bus.ret_addr, 32'h20);
    check("t5_valid", 32'(bus.ret_valid), 1);
    check("t5_count", 32'(bus.count), 2);
    check("t5_top", bus.top_addr, 32'h30);
    @(negedge clk);
    check("t5_valid_drop", 32'(bus.ret_valid), 0);
    op(0, 1, 32'h0);
    check("t5_pop_new_top", bus.ret_addr, 32'h30);
    op(0, 1, 32'h0);
    check("t5_pop_bottom", bus.ret_addr, 32'h10);

    // 5b: replace on empty acts as push and flags underflow
    op(1, 1, 32'h77);
    check("t5b_count", 32'(bus.count), 1);
    check("t5b_top", bus.top_addr, 32'h77);
    check("t5b_unf", 32'(bus.underflow), 1);
    check("t5b_valid", 32'(bus.ret_valid), 0);

    // 6: reset coincident with a pop fire wins
    do_reset();
    for (int i = 0; i < 17; i++) op(1, 0, 32'h2000 + 32'(i));
    for (int i = 0; i < 13; i++) op(0, 1, 32'h0);
    check("t6_pre_count", 32'(bus.count), 3);
    check("t6_pre_ovf", 32'(bus.overflow), 1);
    check("t6_pre_ret", bus.ret_addr, 32'h2003);
    @(negedge clk);
    bus.pop = 1'b1;
    bus.aux_push_pop = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.pop = 1'b0;
    bus.aux_push_pop = 1'b0;
    check("t6_count", 32'(bus.count), 0);
    check("t6_valid", 32'(bus.ret_valid), 0);
    check("t6_ovf", 32'(bus.overflow), 0);
    check("t6_ret", bus.ret_addr, 0);
    check("t6_top", bus.top_addr, 0);
    @(negedge clk);
    check("t6_valid_after", 32'(bus.ret_valid), 0);
    check("t6_count_after", 32'(bus.count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
